// File: rtl/sd_pad_bank.sv
// sd_pad_bank: registered multi-lane SD pad bank (CMD or DAT[LANES-1:0]).
// It drives, parks the bus high, releases it, waits a turnaround and then
// receives with a synchronised input path and lane-0 start-bit detection.

// Per-lane slice: the output data flop and the input synchroniser chain.
module sd_pad_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_data,
  input  logic ld_ones,
  input  logic din,
  input  logic pin,
  output logic out_q,
  output logic sync_o
);
  logic [SYNC_STAGES-1:0] sync_pipe;

  // Output flop: takes host data while driving, forces 1 while parking, else holds.
  always_ff @(posedge clk) begin
    if (!rst_n)       out_q <= 1'b0;
    else if (ld_data) out_q <= din;
    else if (ld_ones) out_q <= 1'b1;
  end

  // Synchroniser runs free in every state; rx_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= SYNC_STAGES'({sync_pipe, pin});
  end

  assign sync_o = sync_pipe[SYNC_STAGES-1];
endmodule

module sd_pad_bank #(
  parameter int LANES       = 1,
  parameter int PARK_CYCLES = 1,
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_SD,
  input  logic             rst_n_SD,
  input  logic             ENB_control,
  input  logic             OutIn_control,
  input  logic [LANES-1:0] data_in_parallelToSerial_PAD,
  input  logic [LANES-1:0] IOin_SD,
  output logic [LANES-1:0] IOout_SD,
  output logic [LANES-1:0] IO_oe_SD,
  output logic [LANES-1:0] data_out_serialToParallel,
  output logic             rx_valid,
  output logic             start_detect,
  output logic             busy_turn
);
  localparam int CNT_MAX   = (PARK_CYCLES > TURNAROUND) ? PARK_CYCLES : TURNAROUND;
  localparam int CW        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int PARK_LD_I = (PARK_CYCLES > 0) ? PARK_CYCLES - 1 : 0;
  localparam int TURN_LD_I = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
  localparam logic [CW-1:0] PARK_LD = CW'(PARK_LD_I);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_LD_I);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRIVE   = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_TURN    = 3'd3;
  localparam logic [2:0] S_RECV    = 3'd4;

  logic [2:0]       state, nstate;
  logic [CW-1:0]    cnt, ncnt;
  logic             oe_q;
  logic             lane0_prev;
  logic             ld_data, ld_ones, rx_entry;
  logic [LANES-1:0] out_q;

  // Next-state and counter reload; counters hold "cycles left minus one".
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    if (!ENB_control) begin
      nstate = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (OutIn_control)        nstate = S_DRIVE;
          else if (TURNAROUND == 0) nstate = S_RECV;
          else begin
            nstate = S_TURN;
            ncnt   = TURN_LD;
          end
        end
        S_DRIVE: begin
          if (!OutIn_control) begin
            if (PARK_CYCLES > 0) begin
              nstate = S_RELEASE;
              ncnt   = PARK_LD;
            end else if (TURNAROUND > 0) begin
              nstate = S_TURN;
              ncnt   = TURN_LD;
            end else begin
              nstate = S_RECV;
            end
          end
        end
        S_RELEASE: begin
          if (OutIn_control) nstate = S_DRIVE;
          else if (cnt == '0) begin
            if (TURNAROUND > 0) begin
              nstate = S_TURN;
              ncnt   = TURN_LD;
            end else begin
              nstate = S_RECV;
            end
          end else begin
            ncnt = cnt - CNT_ONE;
          end
        end
        S_TURN: begin
          if (OutIn_control)  nstate = S_DRIVE;
          else if (cnt == '0) nstate = S_RECV;
          else                ncnt   = cnt - CNT_ONE;
        end
        S_RECV: begin
          if (OutIn_control) nstate = S_DRIVE;
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  assign ld_data  = (nstate == S_DRIVE);
  assign ld_ones  = (nstate == S_RELEASE);
  assign rx_entry = (nstate == S_RECV) && (state != S_RECV);

  // State, counter and registered status outputs, all derived from next state.
  always_ff @(posedge clk_SD) begin
    if (!rst_n_SD) begin
      state        <= S_IDLE;
      cnt          <= '0;
      oe_q         <= 1'b0;
      rx_valid     <= 1'b0;
      busy_turn    <= 1'b0;
      start_detect <= 1'b0;
      lane0_prev   <= 1'b0;
    end else begin
      state        <= nstate;
      cnt          <= ncnt;
      oe_q         <= (nstate == S_DRIVE) || (nstate == S_RELEASE);
      rx_valid     <= (nstate == S_RECV);
      busy_turn    <= (nstate == S_RELEASE) || (nstate == S_TURN);
      // A falling edge needs a 1 seen inside this receive window first.
      start_detect <= (state == S_RECV) && ENB_control && lane0_prev
                      && !data_out_serialToParallel[0];
      lane0_prev   <= rx_entry ? 1'b0 : data_out_serialToParallel[0];
    end
  end

  sd_pad_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [LANES-1:0] (
    .clk     (clk_SD),
    .rst_n   (rst_n_SD),
    .ld_data (ld_data),
    .ld_ones (ld_ones),
    .din     (data_in_parallelToSerial_PAD),
    .pin     (IOin_SD),
    .out_q   (out_q),
    .sync_o  (data_out_serialToParallel)
  );

  assign IO_oe_SD = {LANES{oe_q}};

  // Only the tristate is combinational; each lane floats when its enable is low.
  for (genvar i = 0; i < LANES; i++) begin : g_pad
    assign IOout_SD[i] = IO_oe_SD[i] ? out_q[i] : 1'bz;
  end
endmodule

// File: tb/tb_sd_pad_bank.sv
// tb_sd_pad_bank: directed + randomized checks of sd_pad_bank against a
// timeline model (edges since the host stopped driving) and a pin history queue.
module tb_sd_pad_bank;
  localparam int P = 1;
  localparam int T = 2;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, enb = 1'b0, outin = 1'b0;
  logic [3:0] din = '0, pin = '0;
  wire  [3:0] io_out;
  logic [3:0] io_oe, dout;
  logic       rxv, sdet, busy;

  logic       b_rst_n = 1'b0, b_enb = 1'b0, b_outin = 1'b0;
  logic [3:0] b_din = '0, b_pin = '0;
  wire  [3:0] b_io_out;
  logic [3:0] b_io_oe, b_dout;
  logic       b_rxv, b_sdet, b_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sd_pad_bank #(.LANES(4), .PARK_CYCLES(P), .TURNAROUND(T), .SYNC_STAGES(S)) dut (
    .clk_SD(clk), .rst_n_SD(rst_n), .ENB_control(enb), .OutIn_control(outin),
    .data_in_parallelToSerial_PAD(din), .IOin_SD(pin), .IOout_SD(io_out),
    .IO_oe_SD(io_oe), .data_out_serialToParallel(dout), .rx_valid(rxv),
    .start_detect(sdet), .busy_turn(busy));

  sd_pad_bank #(.LANES(4), .PARK_CYCLES(0), .TURNAROUND(0), .SYNC_STAGES(1)) dut0 (
    .clk_SD(clk), .rst_n_SD(b_rst_n), .ENB_control(b_enb), .OutIn_control(b_outin),
    .data_in_parallelToSerial_PAD(b_din), .IOin_SD(b_pin), .IOout_SD(b_io_out),
    .IO_oe_SD(b_io_oe), .data_out_serialToParallel(b_dout), .rx_valid(b_rxv),
    .start_detect(b_sdet), .busy_turn(b_busy));

  // Model: mode 0 idle, 1 host driving, 2 host receiving (n edges since switch,
  // p = park length that applies to this receive window).
  int         mode = 0, n = 0, p = 0;
  logic [3:0] m_out = '0;
  logic [3:0] hist[$];
  logic       rx_prev = 0, rx_cur = 0, s_prev = 0, s_cur = 0;
  logic       e_oe, e_busy, e_rx, e_start;
  logic [3:0] e_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic o,
                      input logic [3:0] d, input logic [3:0] pn);
    @(negedge clk);
    rst_n = r; enb = e; outin = o; din = d; pin = pn;
    @(posedge clk);
    e_start = r && e && rx_prev && rx_cur && s_prev && !s_cur;
    if (!r) begin
      mode = 0; m_out = '0;
    end else if (!e) begin
      mode = 0;
    end else if (o) begin
      mode = 1; m_out = d;
    end else if (mode == 1) begin
      mode = 2; p = P; n = 1;
      if (P > 0) m_out = 4'hF;
    end else if (mode == 0) begin
      mode = 2; p = 0; n = 1;
    end else begin
      n++;
    end
    e_oe   = (mode == 1) || (mode == 2 && n <= p);
    e_busy = (mode == 2) && (n <= p + T);
    e_rx   = (mode == 2) && (n > p + T);
    if (!r) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(4'h0);
    end else begin
      hist.push_back(pn);
      void'(hist.pop_front());
    end
    e_dout  = hist[0];
    rx_prev = rx_cur; rx_cur = e_rx;
    s_prev  = s_cur;  s_cur  = e_dout[0];
    #1;
    chk("oe", io_oe, {4{e_oe}});
    if (e_oe) chk("pad_out", io_out, m_out);
    chk("dout", dout, e_dout);
    chk("rx_valid", rxv, e_rx);
    chk("busy_turn", busy, e_busy);
    chk("start_detect", sdet, e_start);
  endtask

  logic       r_o, r_e, r_r;
  logic [3:0] r_pin;

  initial begin
    for (int i = 0; i < S; i++) hist.push_back(4'h0);
    // reset, then drive A,5,F,0
    step(0, 1, 1, 4'h3, 4'h0);
    step(1, 1, 1, 4'hA, 4'h0);
    step(1, 1, 1, 4'h5, 4'h0);
    step(1, 1, 1, 4'hF, 4'h0);
    step(1, 1, 1, 4'h0, 4'h0);
    // park, turnaround, receive with lane0 high
    for (int i = 0; i < 5; i++) step(1, 1, 0, 4'h0, 4'hF);
    // lane0 1,1,0,0 -> single start pulse
    step(1, 1, 0, 4'h0, 4'hF);
    step(1, 1, 0, 4'h0, 4'hF);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 4'h0, 4'hE);
    // receive entered with lane0 low: silent until a 1 then 0
    step(1, 1, 1, 4'h7, 4'h0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'h0, 4'h1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4'h0, 4'h0);
    // OutIn=1 mid-TURN
    step(1, 1, 1, 4'h9, 4'h0);
    step(1, 1, 0, 4'h0, 4'h0);
    step(1, 1, 0, 4'h0, 4'h0);
    step(1, 1, 1, 4'h3, 4'h0);
    // ENB=0 mid-DRIVE, then reset mid-DRIVE
    step(1, 0, 1, 4'hC, 4'h0);
    step(1, 1, 1, 4'h6, 4'h0);
    step(0, 1, 1, 4'h9, 4'h5);
    step(1, 1, 1, 4'hB, 4'h5);

    // randomized: held direction runs, occasional disable/reset, toggling lane0
    r_o = 1'b1; r_pin = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) r_o = ~r_o;
      r_e = ($urandom_range(0, 24) != 0);
      r_r = ($urandom_range(0, 99) != 0);
      r_pin[3:1] = 3'($urandom);
      if ($urandom_range(0, 3) == 0) r_pin[0] = ~r_pin[0];
      step(r_r, r_e, r_o, 4'($urandom), r_pin);
    end

    // PARK=0, TURN=0, SYNC=1 instance: drive goes straight to receive
    @(negedge clk); b_rst_n = 0; b_enb = 1; b_outin = 1; b_din = 4'h6; b_pin = 4'h9;
    @(posedge clk); #1;
    chk("z_reset_oe", b_io_oe, 4'h0);
    chk("z_reset_dout", b_dout, 4'h0);
    @(negedge clk); b_rst_n = 1;
    @(posedge clk); #1;
    chk("z_drive_oe", b_io_oe, 4'hF);
    chk("z_drive_out", b_io_out, 4'h6);
    chk("z_dout_sync1", b_dout, 4'h9);
    @(negedge clk); b_outin = 0; b_pin = 4'h2;
    @(posedge clk); #1;
    chk("z_recv_oe", b_io_oe, 4'h0);
    chk("z_recv_rx", b_rxv, 1'b1);
    chk("z_recv_busy", b_busy, 1'b0);
    chk("z_recv_dout", b_dout, 4'h2);
    chk("z_recv_start", b_sdet, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_pad_bank.md
# sd_pad_bank

Parametrised, registered SD-bus pad bank for CMD or DAT[LANES-1:0]. Replaces the single-lane CMD pad with a multi-lane bank that has registered output, synchronised input, an explicit output-enable and a direction state machine. The state machine parks the bus high, waits a turnaround, then receives and flags start bits. It sits between the parallel/serial converters and the SD card pins, and is clocked by the SD bus clock.

## Interface
- LANES, 1: bus width (1 = CMD, 4 or 8 = DAT).
- PARK_CYCLES, 1: cycles the pad drives all-ones after the drive phase, before release (0 = release immediately).
- TURNAROUND, 2: hi-Z cycles between release and receive (0 = receive immediately).
- SYNC_STAGES, 2: input synchroniser depth (1 or 2).
- clk_SD  in  1  SD bus clock; all logic on posedge.
- rst_n_SD  in  1  reset; one clock; reset is synchronous and active-low.
- ENB_control  in  1  bank enable; 0 forces IDLE.
- OutIn_control  in  1  1 = host drives, 0 = host receives.
- data_in_parallelToSerial_PAD  in  LANES  bits to drive this cycle.
- IOin_SD  in  LANES  pin input.
- IOout_SD  out  LANES  pin output; 'z on each lane whose IO_oe_SD bit is 0.
- IO_oe_SD  out  LANES  output enable; all bits equal.
- data_out_serialToParallel  out  LANES  synchronised pin sample.
- rx_valid  out  1  data_out_serialToParallel is valid receive data.
- start_detect  out  1  one-cycle pulse on a start bit on lane 0.
- busy_turn  out  1  state is RELEASE or TURN.

## Operation
- States: IDLE, DRIVE, RELEASE, TURN, RECV. Priority per edge: reset > ENB_control=0 > transitions below.
- IDLE: oe=0. OutIn_control=1 -> DRIVE. OutIn_control=0 -> TURN (counter loaded), or RECV if TURNAROUND=0.
- DRIVE: oe=1. out_reg <= data_in each cycle. OutIn_control=0 -> RELEASE, or TURN if PARK_CYCLES=0.
- RELEASE: oe=1, out_reg <= all-ones. Counter runs PARK_CYCLES cycles, then -> TURN. OutIn_control=1 -> DRIVE immediately, aborting the park.
- TURN: oe=0. Counter runs TURNAROUND cycles, then -> RECV. OutIn_control=1 -> DRIVE.
- RECV: oe=0. rx_valid=1. OutIn_control=1 -> DRIVE.
- ENB_control=0 in any state -> IDLE at next edge. The synchroniser keeps running; rx_valid and start_detect are 0.
- Input path: IOin_SD passes through SYNC_STAGES flops to data_out_serialToParallel. It runs continuously and is qualified by rx_valid.
- Start detect: lane0_prev is cleared to 0 on RECV entry and thereafter tracks synced lane 0. start_detect = RECV & lane0_prev & ~lane0_sync. A line already low at RECV entry does not fire; a 1 must be seen first.
- Counters are sized $clog2(max(PARK_CYCLES, TURNAROUND) + 1). They reload on every entry to RELEASE or TURN; no wrap.

## Timing
- Reset values (one edge with rst_n_SD=0): state IDLE, IO_oe_SD=0, IOout_SD='z, out_reg=0, data_out_serialToParallel=0, synchroniser flops=0, rx_valid=0, start_detect=0, busy_turn=0. Reset mid-DRIVE releases the pins at that edge.
- Drive latency: data_in sampled at edge k appears on IOout_SD after edge k. The first DRIVE edge also raises oe, so there is no cycle of stale data.
- Park: the PARK_CYCLES cycles of all-ones start at the edge that leaves DRIVE; oe drops after the last one.
- Turnaround: oe=0 for exactly TURNAROUND cycles before rx_valid rises.
- Receive latency: pin value to data_out_serialToParallel is SYNC_STAGES edges. start_detect asserts one edge after the synced 1->0 is visible.
- All outputs are registered except IOout_SD tristating, which is a combinational function of oe and out_reg.

## Test plan
- LANES=4 reset, then ENB=1, OutIn=1, data_in=4'hA,5,F,0 on consecutive edges -> IO_oe_SD=4'hF after first edge; IOout_SD=A,5,F,0, each one edge after its input.
- LANES=4, PARK=1, TURN=2: OutIn 1->0 -> IOout_SD=4'hF for 1 cycle, then 'z with busy_turn=1 for 2 cycles, then rx_valid=1.
- In RECV with SYNC=2, lane0 driven 1,1,0,0 -> data_out lane0 follows 2 edges later; start_detect pulses exactly once, on the 1->0.
- Enter RECV with lane0 held 0 -> no start_detect; lane0 then goes 1 then 0 -> one pulse.
- OutIn=1 mid-TURN -> DRIVE next edge with oe=1 and data_in on pins. ENB=0 mid-DRIVE -> oe=0 next edge.
- rst_n_SD=0 for one edge mid-DRIVE -> all outputs at reset values next edge; PARK=0, TURN=0 -> DRIVE goes straight to RECV in one edge.
